// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM backend: FSM states and SRAM geometry.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int SRAM_AW = 18;   // halfword address width (256K x 16)
    localparam int SRAM_DW = 16;   // SRAM data bus width
    localparam int LINE_HW = 4;    // halfwords per cache line
    localparam int WORD_HW = 2;    // halfwords per store word

endpackage

// File: rtl/sram_controller_if.sv
// Request/response bus between the cache controller and the SRAM backend.
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [63:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Cache backend for a 16-bit asynchronous SRAM: 64-bit line reads as four
// halfword reads, 32-bit word writes as two halfword writes, each halfword
// taking ACCESS_CYCLES clocks.
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ACCESS_CYCLES = 2
)(
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [3:0] WC_LAST      = 4'(ACCESS_CYCLES - 1);
    localparam logic [1:0] HW_LINE_LAST = 2'(LINE_HW - 1);
    localparam logic [1:0] HW_WORD_LAST = 2'(WORD_HW - 1);

    state_t             state, state_next;
    logic [1:0]         hw, hw_next;
    logic [3:0]         wc, wc_next;
    logic [SRAM_AW-1:0] off_hw;
    logic [SRAM_AW-1:0] base_q;
    logic [31:0]        wdata_q;
    logic [63:0]        rdata_q;
    logic               ready_c;
    logic               we_n_c;
    logic               oe_n_c;
    logic               dq_oe;
    logic               accept;
    logic               capture;

    // Only offset bits [18:1] matter, so the subtraction is done modulo 2^19.
    assign off_hw = SRAM_AW'((bus.address[18:0] - BASE_ADDR[18:0]) >> 1);

    // State and counter registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            hw    <= '0;
            wc    <= '0;
        end else begin
            state <= state_next;
            hw    <= hw_next;
            wc    <= wc_next;
        end
    end

    // Next-state, counter stepping and SRAM strobe decode.
    always_comb begin
        state_next = state;
        hw_next    = hw;
        wc_next    = wc;
        ready_c    = 1'b0;
        we_n_c     = 1'b1;
        oe_n_c     = 1'b1;
        dq_oe      = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_c = ~(bus.rd_en | bus.wr_en);
                accept  = bus.rd_en | bus.wr_en;
                hw_next = '0;
                wc_next = '0;
                if (bus.wr_en)      state_next = ST_WRITE;
                else if (bus.rd_en) state_next = ST_READ;
            end
            ST_READ: begin
                oe_n_c = 1'b0;
                if (wc == WC_LAST) begin
                    capture = 1'b1;
                    wc_next = '0;
                    hw_next = hw + 2'd1;
                    if (hw == HW_LINE_LAST) state_next = ST_DONE;
                end else begin
                    wc_next = wc + 4'd1;
                end
            end
            ST_WRITE: begin
                dq_oe = 1'b1;
                // WE_N rises on the last cycle while address and data stay put.
                we_n_c = (wc == WC_LAST);
                if (wc == WC_LAST) begin
                    wc_next = '0;
                    if (hw == HW_WORD_LAST) begin
                        hw_next    = '0;
                        state_next = ST_DONE;
                    end else begin
                        hw_next = hw + 2'd1;
                    end
                end else begin
                    wc_next = wc + 4'd1;
                end
            end
            ST_DONE: begin
                ready_c    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch and line-capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                base_q  <= bus.wr_en ? {off_hw[SRAM_AW-1:1], 1'b0}
                                     : {off_hw[SRAM_AW-1:2], 2'b00};
                wdata_q <= bus.write_data;
            end
            if (capture) rdata_q[{hw, 4'b0000} +: 16] <= SRAM_DQ;
        end
    end

    assign SRAM_DQ       = dq_oe ? (hw[0] ? wdata_q[31:16] : wdata_q[15:0]) : 'z;
    assign SRAM_ADDR     = base_q + SRAM_AW'(hw);
    assign SRAM_WE_N     = we_n_c;
    assign SRAM_OE_N     = oe_n_c;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign bus.ready     = ready_c;
    assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: two controllers (2 and 4 wait cycles) on behavioural
// SRAMs, compared against a shadow memory and latency/pin-timing formulas.
module tb_sram_controller;
    import sram_pkg::*;

    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sram_controller_if bus0 ();
    sram_controller_if bus1 ();

    wire  [15:0] dq0, dq1;
    logic [17:0] addr0, addr1;
    logic        we0, oe0, ce0, ub0, lb0;
    logic        we1, oe1, ce1, ub1, lb1;

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // Behavioural SRAMs: drive DQ only when reading, store while WE_N is low.
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    logic        pre_en0 = 1'b0, pre_en1 = 1'b0;
    logic [17:0] pre_a = '0;
    logic [15:0] pre_d = '0;

    assign dq0 = (!oe0 && we0 && !ce0) ? mem0[addr0] : 16'hzzzz;
    assign dq1 = (!oe1 && we1 && !ce1) ? mem1[addr1] : 16'hzzzz;

    always @(posedge clk) begin
        if (pre_en0)               mem0[pre_a] <= pre_d;
        else if (!we0 && !ce0)     mem0[addr0] <= dq0;
    end

    always @(posedge clk) begin
        if (pre_en1)               mem1[pre_a] <= pre_d;
        else if (!we1 && !ce1)     mem1[addr1] <= dq1;
    end

    // Reference: expected contents of halfwords 0..63 and last returned line.
    logic [15:0] sh0 [0:63];
    logic [15:0] sh1 [0:63];
    logic [63:0] last_rd [0:1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic        g_rdy (input int s); return s != 0 ? bus1.ready : bus0.ready; endfunction
    function automatic logic [63:0] g_rd  (input int s); return s != 0 ? bus1.read_data : bus0.read_data; endfunction
    function automatic logic [17:0] g_addr(input int s); return s != 0 ? addr1 : addr0; endfunction
    function automatic logic        g_we  (input int s); return s != 0 ? we1 : we0; endfunction
    function automatic logic        g_oe  (input int s); return s != 0 ? oe1 : oe0; endfunction
    function automatic logic [15:0] g_mem (input int s, input int i); return s != 0 ? mem1[i] : mem0[i]; endfunction
    function automatic logic [15:0] g_sh  (input int s, input int i); return s != 0 ? sh1[i] : sh0[i]; endfunction

    task automatic drive(input int s, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (s != 0) begin
            bus1.rd_en = rd; bus1.wr_en = wr; bus1.address = a; bus1.write_data = d;
        end else begin
            bus0.rd_en = rd; bus0.wr_en = wr; bus0.address = a; bus0.write_data = d;
        end
    endtask

    task automatic preload(input int s, input int idx, input logic [15:0] val);
        pre_a = 18'(idx);
        pre_d = val;
        if (s != 0) begin pre_en1 = 1'b1; sh1[idx] = val; end
        else        begin pre_en0 = 1'b1; sh0[idx] = val; end
        @(posedge clk); #1;
        pre_en0 = 1'b0;
        pre_en1 = 1'b0;
    endtask

    // One complete transaction from the IDLE request cycle back to IDLE.
    task automatic do_op(input int s, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
        int          ac   = (s != 0) ? 4 : 2;
        logic [31:0] off  = a - BASE;
        int          nhw  = wr ? 2 : 4;
        int          base = wr ? int'(off[18:2]) * 2 : int'(off[18:3]) * 4;
        int          lat  = nhw * ac + 1;
        int          k    = 0;
        logic [63:0] exp_rd;
        drive(s, rd, wr, a, d);
        #1;
        chk({tag, "_req_ready"}, 64'(g_rdy(s)), 64'd0);
        do begin
            @(posedge clk); #1;
            k++;
            if (!g_rdy(s) && k < lat) begin
                chk({tag, "_addr"}, 64'(g_addr(s)), 64'(base + (k - 1) / ac));
                chk({tag, "_oe_n"}, 64'(g_oe(s)), wr ? 64'd1 : 64'd0);
                chk({tag, "_we_n"}, 64'(g_we(s)),
                    (!wr || ((k - 1) % ac) == ac - 1) ? 64'd1 : 64'd0);
            end
        end while (!g_rdy(s) && k < 200);
        chk({tag, "_latency"}, 64'(k), 64'(lat));
        if (wr) begin
            if (s != 0) begin sh1[base] = d[15:0]; sh1[base + 1] = d[31:16]; end
            else        begin sh0[base] = d[15:0]; sh0[base + 1] = d[31:16]; end
            chk({tag, "_rd_kept"}, g_rd(s), last_rd[s]);
        end else begin
            exp_rd = {g_sh(s, base + 3), g_sh(s, base + 2), g_sh(s, base + 1), g_sh(s, base)};
            chk({tag, "_rdata"}, g_rd(s), exp_rd);
            last_rd[s] = exp_rd;
        end
        drive(s, 1'b0, 1'b0, a, d);
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, 64'(g_rdy(s)), 64'd1);
        if (wr) begin
            chk({tag, "_mem_lo"}, 64'(g_mem(s, base)), 64'(g_sh(s, base)));
            chk({tag, "_mem_hi"}, 64'(g_mem(s, base + 1)), 64'(g_sh(s, base + 1)));
        end
    endtask

    initial begin
        logic [63:0] part;
        logic [31:0] ra, rdat;
        int          rs, kind;

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_ready0", 64'(bus0.ready), 64'd1);
        chk("rst_ready1", 64'(bus1.ready), 64'd1);
        chk("rst_we_n", 64'(we0), 64'd1);
        chk("rst_oe_n", 64'(oe0), 64'd1);
        chk("rst_rdata", bus0.read_data, 64'd0);
        chk("rst_addr", 64'(addr0), 64'd0);
        chk("rst_ties", {61'd0, ce0, ub0, lb0}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            preload(0, i, 16'($urandom));
            preload(1, i, 16'($urandom));
        end

        // Write at SRAM location 0.
        do_op(0, 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, "t2_wr");
        chk("t2_mem0", 64'(mem0[0]), 64'h0000_0000_0000_BEEF);
        chk("t2_mem1", 64'(mem0[1]), 64'h0000_0000_0000_DEAD);

        // Line read of halfwords 4..7, then an unaligned address in the same line.
        preload(0, 4, 16'h1111);
        preload(0, 5, 16'h2222);
        preload(0, 6, 16'h3333);
        preload(0, 7, 16'h4444);
        do_op(0, 1'b1, 1'b0, 32'd1032, '0, "t3_rd");
        chk("t3_line", bus0.read_data, 64'h4444_3333_2222_1111);
        do_op(0, 1'b1, 1'b0, 32'd1038, '0, "t4_rd");
        chk("t4_line", bus0.read_data, 64'h4444_3333_2222_1111);

        // Reset in the middle of a read, with halfwords 0 and 1 already captured.
        drive(0, 1'b1, 1'b0, 32'd1032, '0);
        repeat (5) @(posedge clk);
        #1;
        part = bus0.read_data;
        chk("t1_partial", {32'd0, part[31:0]}, 64'h0000_0000_2222_1111);
        rst = 1'b1;
        #1;
        chk("t1_we_n", 64'(we0), 64'd1);
        chk("t1_oe_n", 64'(oe0), 64'd1);
        chk("t1_rdata", bus0.read_data, 64'd0);
        chk("t1_addr", 64'(addr0), 64'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        #1;
        chk("t1_ready", 64'(bus0.ready), 64'd1);

        // Simultaneous requests: the write wins.
        do_op(0, 1'b1, 1'b1, 32'd1040, 32'h0000_00A5, "t5_both");
        chk("t5_mem8", 64'(mem0[8]), 64'h0000_0000_0000_00A5);

        // Four wait cycles: write then read back the same word.
        do_op(1, 1'b0, 1'b1, 32'd1044, 32'hCAFE_F00D, "t6_wr");
        do_op(1, 1'b1, 1'b0, 32'd1044, '0, "t6_rd");
        part = bus1.read_data;
        chk("t6_word", {32'd0, part[63:32]}, 64'h0000_0000_CAFE_F00D);

        // Random mix over a 128-byte window, sometimes with ignored high bits.
        for (int n = 0; n < 60; n++) begin
            rs   = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            ra   = BASE + 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) ra = ra + ($urandom << 19);
            rdat = $urandom;
            do_op(rs, kind != 1, kind != 0, ra, rdat, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
